rename_dispatch_sequencer: RTL
==============================

Name: rename_dispatch_sequencer

Overview:
Sequences 3-wide decoded instruction groups into the register alias table and free-list rename stage. It holds one group in a 3-slot buffer and each cycle releases the largest in-order prefix that fits. The prefix is limited by free physical registers, ROB credits and reservation-station credits; leftovers are compacted to slot 0 and retried. It also owns pipeline-flush sequencing for the rename front end.

Parameters:
PAYLOAD_W, 64, opaque per-slot instruction payload width (arch reg fields, opcode, PC bits)
FREE_CNT_W, 6, width of free-register count from the rename free list
STALL_CNT_W, 32, width of saturating stall performance counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  3  per-slot valid of decode group; must be prefix-packed (1, 11, 111)
in_need_rd  in  3  per-slot: instruction writes rd != x0 (needs physical register)
in_payload  in  3*PAYLOAD_W  slot i at [i*PAYLOAD_W +: PAYLOAD_W]
in_ready  out  1  group accepted on in_ready && |in_valid
free_count  in  FREE_CNT_W  free physical registers available this cycle
rob_credit  in  2  ROB slots available, pre-clamped 0..3
rs_credit  in  2  reservation-station slots available, 0..3
out_valid  out  3  prefix-packed slots presented to rename this cycle (drives decode_valid)
out_need_rd  out  3  out_valid & buffered need_rd (drives rd_write_enable)
out_payload  out  3*PAYLOAD_W  buffered payload, slot-aligned with out_valid
flush  in  1  branch-mispredict/exception flush request
flush_done  in  1  ROB reports recovery complete
busy  out  1  buffer non-empty or state != RUN
stall_count  out  STALL_CNT_W  cycles with buffered work but zero dispatched

Behaviour:
- Reset, asynchronous, active-low: state=RUN, buffer empty, out_valid=0, out_need_rd=0, out_payload=0, in_ready=1, busy=0, stall_count=0.
- States:
  - RUN: normal operation.
  - FLUSH: buffer cleared, waiting for flush_done.
  - RESTART: one-cycle bubble, then RUN.
- Dispatch count k (combinational, RUN only): largest n in 0..3 such that:
  - n <= buffered valid count;
  - popcount(need_rd[n-1:0]) <= free_count, compared at FREE_CNT_W width with no truncation;
  - n <= rob_credit;
  - n <= rs_credit.
- out_valid[i]=1 for i<k, otherwise 0. Outputs are driven from the buffer, so latency is 1 cycle from acceptance.
- No skipping: if slot j cannot dispatch, no slot >j dispatches.
- Compaction: after dispatching k slots, remaining slots move to slot i-k next cycle and their need_rd/payload move with them. Vacated slots go invalid, with payload held (don't-care).
- in_ready = RUN && (buffer empty || k == buffered count). Acceptance in the same cycle as full drain loads the new group for the next cycle; no bubble.
- stall_count increments, saturating at all-ones, when RUN, buffer non-empty and k=0.
- flush has highest priority, in any state:
  - next state FLUSH; buffer cleared next cycle;
  - out_valid forced 0 and in_ready forced 0 in the flush cycle itself; any concurrent input group is dropped.
- FLUSH: out_valid=0, in_ready=0; stays until flush_done=1, then RESTART.
- flush and flush_done both high: flush wins and the block stays in FLUSH.
- RESTART: out_valid=0, in_ready=0 for one cycle, then RUN.
- free_count=0 with need_rd=000: dispatch still proceeds; only the ROB/RS credits limit it.
- Assertions:
  - in_valid not prefix-packed while in_ready;
  - rob_credit > 3 or rs_credit > 3 never occurs by port width (clamp upstream);
  - out_valid is always prefix-packed.

Decomposition:
- Shared package rename_pkg:
  - SLOTS=3 constant;
  - seq_state_t enum {RUN, FLUSH, RESTART};
  - slot_t struct {valid, need_rd, payload};
  - function prefix_popcount.
- One sub-module, dispatch_prefix_calc: purely combinational computation of k from the buffer valid/need_rd bits, free_count and credits. The top level holds the FSM, buffer, compaction and counter.

Test Plan:
- Full-resource pass: group 111, need_rd=111, free=10, credits 3/3 -> accepted; next cycle out_valid=111, in_ready=1; back-to-back groups stream with no bubbles.
- Free-list limit: need_rd=111, free=1 -> out_valid=001; then slots 1,2 compacted to 0,1; with free=2 next cycle -> out_valid=011, buffer empty, in_ready=1.
- Non-writer bypass: need_rd=010, free=0, credits 3/3 -> out_valid=001, stall with slot1 at slot0; stall_count increments each cycle until free=1 -> out_valid=011.
- Credit limit: rob_credit=2, rs_credit=1, need_rd=000 -> out_valid=001 per cycle over three cycles; stall_count unchanged.
- Flush mid-stall: buffer holding 2 slots, flush=1 -> next cycle busy=1, out_valid=0, in_ready=0; flush_done after 5 cycles -> one RESTART cycle, then in_ready=1, buffer empty.
- Reset mid-operation: assert reset while in FLUSH with nonzero stall_count -> all outputs at reset values immediately (asynchronous), state RUN after release.

Source files
------------

// File: rtl/rename_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rename_pkg
// Brief    : Shared types and helpers for the rename dispatch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package rename_pkg;

    localparam int SLOTS         = 3;
    // Storage width of a buffered payload; instance payloads must not exceed it.
    localparam int PAYLOAD_MAX_W = 64;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        RESTART = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic                     valid;
        logic                     need_rd;
        logic [PAYLOAD_MAX_W-1:0] payload;
    } slot_t;

    function automatic logic [1:0] prefix_popcount(input logic [SLOTS-1:0] bits,
                                                   input logic [1:0]       n);
        logic [1:0] cnt;
        cnt = 2'd0;
        for (int i = 0; i < SLOTS; i++) begin
            if ((i < int'(n)) && bits[i]) begin
                cnt = cnt + 2'd1;
            end
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_prefix_calc.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_prefix_calc
// Brief    : Largest in-order slot prefix that fits free regs and credits.
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_prefix_calc
    import rename_pkg::*;
#(
    parameter int FREE_CNT_W = 6
) (
    input  logic [SLOTS-1:0]      i_buf_valid,
    input  logic [SLOTS-1:0]      i_buf_need_rd,
    input  logic [FREE_CNT_W-1:0] i_free_count,
    input  logic [1:0]            i_rob_credit,
    input  logic [1:0]            i_rs_credit,
    output logic [1:0]            o_k
);

    // Every limit is monotonic in n, so the last passing n is the answer and
    // no later slot can ever slip past a blocked one.
    always_comb begin
        o_k = 2'd0;
        for (int n = 1; n <= SLOTS; n++) begin
            if (i_buf_valid[n-1] &&
                (FREE_CNT_W'(prefix_popcount(i_buf_need_rd, 2'(n))) <= i_free_count) &&
                (2'(n) <= i_rob_credit) &&
                (2'(n) <= i_rs_credit)) begin
                o_k = 2'(n);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rename_dispatch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rename_dispatch_sequencer
// Brief    : Buffers a 3-wide decode group, releases fitting prefixes to
//            rename, compacts leftovers and sequences front-end flushes.
// Revision : 1.0 - initial release
// ============================================================================
module rename_dispatch_sequencer
    import rename_pkg::*;
#(
    parameter int PAYLOAD_W   = 64,
    parameter int FREE_CNT_W  = 6,
    parameter int STALL_CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SLOTS-1:0]           in_valid,
    input  logic [SLOTS-1:0]           in_need_rd,
    input  logic [SLOTS*PAYLOAD_W-1:0] in_payload,
    output logic                       in_ready,
    input  logic [FREE_CNT_W-1:0]      free_count,
    input  logic [1:0]                 rob_credit,
    input  logic [1:0]                 rs_credit,
    output logic [SLOTS-1:0]           out_valid,
    output logic [SLOTS-1:0]           out_need_rd,
    output logic [SLOTS*PAYLOAD_W-1:0] out_payload,
    input  logic                       flush,
    input  logic                       flush_done,
    output logic                       busy,
    output logic [STALL_CNT_W-1:0]     stall_count
);

    seq_state_t             r_state;
    seq_state_t             w_next_state;
    slot_t                  r_slot     [SLOTS];
    slot_t                  w_slot_nxt [SLOTS];
    logic [STALL_CNT_W-1:0] r_stall;

    logic [SLOTS-1:0] w_buf_valid;
    logic [SLOTS-1:0] w_buf_need;
    logic [1:0]       w_buf_cnt;
    logic [1:0]       w_k;
    logic [1:0]       w_k_eff;
    logic             w_run;
    logic             w_empty;
    logic             w_accept;
    logic             w_stall_inc;
    logic [2:0]       w_src;

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            w_buf_valid[i] = r_slot[i].valid;
            w_buf_need[i]  = r_slot[i].need_rd;
        end
    end

    dispatch_prefix_calc #(
        .FREE_CNT_W (FREE_CNT_W)
    ) u_prefix_calc (
        .i_buf_valid   (w_buf_valid),
        .i_buf_need_rd (w_buf_need),
        .i_free_count  (free_count),
        .i_rob_credit  (rob_credit),
        .i_rs_credit   (rs_credit),
        .o_k           (w_k)
    );

    assign w_buf_cnt   = prefix_popcount(w_buf_valid, 2'd3);
    assign w_empty     = (w_buf_cnt == 2'd0);
    assign w_run       = (r_state == RUN) && !flush;
    assign w_k_eff     = w_run ? w_k : 2'd0;
    assign in_ready    = w_run && (w_empty || (w_k == w_buf_cnt));
    assign w_accept    = in_ready && (|in_valid);
    assign w_stall_inc = (r_state == RUN) && !w_empty && (w_k == 2'd0) && (r_stall != '1);
    assign busy        = !w_empty || (r_state != RUN);
    assign stall_count = r_stall;

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            out_valid[i]                            = (i < int'(w_k_eff));
            out_need_rd[i]                          = (i < int'(w_k_eff)) && w_buf_need[i];
            out_payload[i*PAYLOAD_W +: PAYLOAD_W]   = r_slot[i].payload[PAYLOAD_W-1:0];
        end
    end

    // Load only happens on full drain, so it simply overwrites the buffer.
    always_comb begin
        w_src = 3'd0;
        for (int i = 0; i < SLOTS; i++) begin
            w_slot_nxt[i] = r_slot[i];
        end
        if (flush) begin
            for (int i = 0; i < SLOTS; i++) begin
                w_slot_nxt[i].valid   = 1'b0;
                w_slot_nxt[i].need_rd = 1'b0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < SLOTS; i++) begin
                w_slot_nxt[i].valid                     = in_valid[i];
                w_slot_nxt[i].need_rd                   = in_need_rd[i];
                w_slot_nxt[i].payload                   = '0;
                w_slot_nxt[i].payload[PAYLOAD_W-1:0]    = in_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end else if (r_state == RUN) begin
            for (int i = 0; i < SLOTS; i++) begin
                w_src = 3'(i) + {1'b0, w_k};
                if (w_src < 3'(SLOTS)) begin
                    w_slot_nxt[i] = r_slot[w_src[1:0]];
                end else begin
                    w_slot_nxt[i].valid   = 1'b0;
                    w_slot_nxt[i].need_rd = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = FLUSH;
        end else begin
            case (r_state)
                RUN:     w_next_state = RUN;
                FLUSH:   w_next_state = flush_done ? RESTART : FLUSH;
                RESTART: w_next_state = RUN;
                default: w_next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_stall <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            for (int i = 0; i < SLOTS; i++) begin
                r_slot[i] <= w_slot_nxt[i];
            end
            if (w_stall_inc) begin
                r_stall <= r_stall + STALL_CNT_W'(1);
            end
        end
    end

    // Credits above 3 cannot be expressed on the 2-bit credit ports.
    a_in_packed: assert property (@(posedge clk) disable iff (!reset)
        in_ready |-> (in_valid inside {3'b000, 3'b001, 3'b011, 3'b111}));

    a_out_packed: assert property (@(posedge clk) disable iff (!reset)
        out_valid inside {3'b000, 3'b001, 3'b011, 3'b111});

endmodule
`default_nettype wire
